// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID register: PC generation, imem req/ack handshake, branch redirect.
// Optional IF_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_reg_q, pc_reg_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        pending_q, pending_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        consume_s;
  logic        slot_free_s;
  logic        accept_s;

  assign consume_s   = valid_q & ~freeze;
  assign slot_free_s = ~valid_q | consume_s;

  // Memory request: a new fetch only starts into a free slot; once started it is held until ack.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_reg_q;
    case (state_q)
      ST_FETCH: begin
        imem_req  = pending_q | slot_free_s;
        imem_addr = pc_reg_q;
      end
      ST_HOLD: begin
        imem_req  = 1'b0;
        imem_addr = pc_reg_q;
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
      end
      default: begin
        imem_req  = 1'b0;
        imem_addr = pc_reg_q;
      end
    endcase
  end

  // Next-state, PC and output-buffer update.
  always_comb begin
    state_d      = state_q;
    pc_reg_d     = pc_reg_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    pending_d    = pending_q;
    drain_addr_d = drain_addr_q;
    accept_s     = 1'b0;

    if (consume_s) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else begin
      valid_d = valid_q;
    end

    if (branch_taken) begin
      pc_reg_d  = branch_address & 32'hFFFF_FFFC;
      valid_d   = 1'b0;
      instr_d   = NOP_INSTR;
      pending_d = 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (imem_req && !imem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_reg_q;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_HOLD:  state_d = ST_FETCH;
        ST_DRAIN: state_d = imem_ack ? ST_FETCH : ST_DRAIN;
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!imem_req) begin
            state_d = ST_HOLD;
          end else if (!imem_ack) begin
            pending_d = 1'b1;
          end else if (slot_free_s) begin
            pc_d      = pc_reg_q + 32'd4;
            instr_d   = imem_rdata;
            valid_d   = 1'b1;
            pc_reg_d  = pc_reg_q + 32'd4;
            pending_d = 1'b0;
            accept_s  = 1'b1;
          end else begin
            // Unreachable: drop the data and refetch the same address once the slot frees.
            state_d   = ST_HOLD;
            pending_d = 1'b0;
          end
        end
        ST_HOLD:  state_d = consume_s ? ST_FETCH : ST_HOLD;
        ST_DRAIN: state_d = imem_ack ? ST_FETCH : ST_DRAIN;
        default:  state_d = ST_FETCH;
      endcase
    end
  end

  // State and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_FETCH;
      pc_reg_q     <= RESET_PC;
      pc_q         <= 32'h0000_0000;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      pending_q    <= 1'b0;
      drain_addr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_reg_q     <= pc_reg_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      pending_q    <= pending_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  assign pc          = pc_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_s;

  assign stall_s = (imem_req & ~imem_ack) | (state_q == ST_HOLD);

  // Counter increments (wrapping).
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept_s) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (stall_s) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
